data_mem_responder: RTL

- Memory-side responder for the processor's data load/store requests.
- Accepts one request at a time over a valid/ready handshake and models a fixed number of wait states.
- Performs the word read or write on an internal RAM, then returns data and an error flag over a valid/ready response channel.
- Sits between the core's load/store path and the data RAM; allows multi-cycle memory timing without changing the core.

---
 rtl/data_mem_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-side memory responder: one request at a time, fixed wait states.
// Define DMEM_PERF_EN to add load/store/error performance counters.
module data_mem_responder #(
  parameter int ADDR_WORDS_LOG2 = 10,
  parameter int WAIT_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [15:0] perf_errs
`endif
);

  localparam int AW    = ADDR_WORDS_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          cap_write;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_wdata;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic          acc_err;
  logic          enter_resp;
  logic          mem_we;

  assign idx        = cap_addr[AW+1:2];
  assign acc_err    = (cap_addr[1:0] != 2'b00) | (|cap_addr[31:AW+2]);
  // RESP with no response yet raised is the single access edge
  assign enter_resp = (state == RESP) & ~resp_valid;
  assign mem_we     = enter_resp & cap_write & ~acc_err;

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= cap_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              cnt   <= CW'(WAIT_CYCLES - 1);
              state <= WAIT;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else cnt <= cnt - CW'(1);
        end
        RESP: begin
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp_err   <= acc_err;
            resp_rdata <= (!cap_write && !acc_err) ? mem[idx] : '0;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_errs   <= '0;
    end else if (enter_resp) begin
      if (acc_err) begin
        if (perf_errs != 16'hFFFF) perf_errs <= perf_errs + 16'd1;
      end else if (cap_write) begin
        perf_stores <= perf_stores + 32'd1;
      end else begin
        perf_loads <= perf_loads + 32'd1;
      end
    end
  end
`endif

endmodule
